multicycle_alu: RTL
===================

// Module: multicycle_alu
// PURPOSE
//  Parametrised successor to the single-cycle CPU ALU, for the multi-cycle datapath.
//  Executes single-cycle logic/arith/shift ops plus iterative multiply and unsigned divide.
//  Uses a start/busy/done handshake.
//  Output is registered: the control FSM samples done and result, and enables the register-file write.
// PARAMETERS
//  WIDTH   32   operand/result width, >=8, power of two; localparam SHW = $clog2(WIDTH)
// PORTS
//  clk     in   1      clock, rising edge
//  rst     in   1      reset, asynchronous, active-high
//  start   in   1      launch op; accepted only when busy=0
//  op      in   4      operation code, sampled with start
//  a       in   WIDTH  operand A, sampled with start
//  b       in   WIDTH  operand B / shift amount (b[SHW-1:0]), sampled with start
//  busy    out  1      iterative op in progress
//  done    out  1      one-cycle pulse: result/flags valid
//  result  out  WIDTH  registered result, held until next accepted op
//  zero    out  1      result==0, registered with result
//  ovf     out  1      signed overflow of ADD/SUB, else 0
//  div0    out  1      DIVU/REMU with b==0, else 0
// BEHAVIOUR
//  Reset (async, any time, incl. mid-op):
//   state=IDLE, busy=0, done=0, result=0, zero=1, ovf=0, div0=0; partial iteration discarded.
//  Op codes:
//   0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR (bitwise ~(a|b)), 5 SRL, 6 SUB, 7 SLT (signed),
//   8 SLL, 9 SRA, A SLTU, B MUL (low WIDTH bits), C DIVU (quotient), D REMU.
//   E/F reserved -> result 0, 1 cycle.
//  Arithmetic: ADD/SUB wrap mod 2^WIDTH; ovf = operand signs equal(ADD)/differ(SUB) and result sign differs.
//  Shifts: amount = b[SHW-1:0]; upper b bits ignored.
//  FSM states: IDLE, RUN, DONE.
//   IDLE + start + single-cycle op -> compute, register result -> DONE. Latency 1.
//   IDLE + start + MUL/DIVU/REMU -> latch a,b, counter=WIDTH -> RUN, busy=1.
//   RUN: one shift-add (MUL) or one restoring-subtract step (DIV) per cycle; counter--;
//        counter hits 0 -> DONE. Latency WIDTH+1; busy high exactly WIDTH cycles.
//   DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
//   start in DONE is ignored; next op is accepted in IDLE, so back-to-back issue is every 2 cycles.
//  start while busy=1 or in DONE: ignored; op/a/b changes have no effect on the op in flight.
//  Divide by zero: skip iteration, 1-cycle latency, quotient all ones, remainder = a, div0=1.
//  result/zero/ovf/div0 update only at completion; they are stable between done pulses.
// CONFIGURATION
//  ALU_DIV_EN defined:
//   DIVU/REMU implemented as above.
//  ALU_DIV_EN undefined:
//   no divider logic; DIVU/REMU behave as reserved codes (result 0, latency 1, div0=0).
//   MUL unaffected.
// TESTING (WIDTH=32)
//  1. ADD a=0x7FFFFFFF b=1 -> done 1 cycle after start; result 0x80000000, ovf=1, zero=0.
//  2. SUB a=5 b=5 -> result 0, zero=1, ovf=0.
//     NOR a=0 b=0 -> result 0xFFFFFFFF.
//  3. MUL a=0x00010003 b=5:
//     -> busy high 32 cycles, done at cycle 33, result 0x0005000F.
//     A start pulse with ADD at cycle 5 is ignored (the result is still 0x0005000F).
//  4. DIVU 100/7 -> 14; REMU 100/7 -> 2.
//     DIVU a=9 b=0 -> result 0xFFFFFFFF, div0=1, latency 1.
//  5. SRA a=0x80000000 b=0x24 -> result 0xF8000000 (shamt 4).
//     SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
//  6. rst pulse at cycle 10 of MUL:
//     -> busy=0, done=0, result=0 immediately, with no done pulse.
//     ADD 2+3 issued after release -> result 5.
//     Without ALU_DIV_EN: DIVU 100/7 -> result 0, latency 1.

Source files
------------

// File: rtl/multicycle_alu.sv
// multicycle_alu: ALU for the multi-cycle datapath. Single-cycle
// logic/arith/shift ops plus iterative shift-add multiply and
// restoring unsigned divide, behind a start/busy/done handshake.
// Configuration macro: ALU_DIV_EN (when undefined, DIVU/REMU are
// treated as reserved op codes and no divider logic is built).
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   start          launch request, accepted only in IDLE
//   op, a, b       op code and operands, sampled with start
//   busy           iterative op in progress
//   done           one-cycle pulse, result and flags valid
//   result, zero   registered result and result==0 flag
//   ovf            signed overflow of ADD/SUB
//   div0           DIVU/REMU with b==0
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             div0
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_SLTU = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_DIVU = 4'hC;
    localparam logic [3:0] OP_REMU = 4'hD;

    logic [1:0]       r_state;
    logic [SHW:0]     r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_div0;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic             w_ovf;
    logic             w_div0;
    logic             w_div_go;
    logic             w_iter;

    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_x_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic [WIDTH-1:0] w_fin;

    assign w_sum   = a + b;
    assign w_dif   = a - b;
    assign w_shamt = b[SHW-1:0];

    // Iterative divide only runs for a non-zero divisor; division by
    // zero completes in one cycle through the single-cycle path.
`ifdef ALU_DIV_EN
    assign w_div_go = ((op == OP_DIVU) || (op == OP_REMU)) && (b != '0);
`else
    assign w_div_go = 1'b0;
`endif

    assign w_iter = (op == OP_MUL) || w_div_go;

    // Single-cycle result path
    always_comb begin
        w_alu  = '0;
        w_ovf  = 1'b0;
        w_div0 = 1'b0;
        case (op)
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_ADD: begin
                w_alu = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  w_alu = a ^ b;
            OP_NOR:  w_alu = ~(a | b);
            OP_SRL:  w_alu = a >> w_shamt;
            OP_SUB: begin
                w_alu = w_dif;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                        (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLL:  w_alu = a << w_shamt;
            OP_SRA:  w_alu = $signed(a) >>> w_shamt;
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, a < b};
`ifdef ALU_DIV_EN
            // Only reached with b==0; non-zero divisors iterate.
            OP_DIVU: begin
                w_alu  = '1;
                w_div0 = (b == '0);
            end
            OP_REMU: begin
                w_alu  = a;
                w_div0 = (b == '0);
            end
`endif
            default: w_alu = '0;
        endcase
    end

    // Multiply: r_acc = partial product, r_x = multiplicand (shifts
    // left), r_y = multiplier (shifts right, LSB selects the add).
    assign w_mul_acc = r_y[0] ? (r_acc + r_x) : r_acc;

`ifdef ALU_DIV_EN
    // Divide: r_acc = partial remainder, r_x = divisor, r_y holds the
    // dividend, shifting out MSB-first while quotient bits shift in.
    logic             r_div;
    logic             r_rem;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_sub;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_rem_sh  = {r_acc, r_y[WIDTH-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_x};
    // No borrow out of the trial subtraction means it fits.
    assign w_q_bit   = ~w_rem_sub[WIDTH];
    assign w_rem_nxt = w_q_bit ? w_rem_sub[WIDTH-1:0]
                               : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_y[WIDTH-2:0], w_q_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= 1'b0;
            r_rem <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_div <= w_div_go;
            r_rem <= (op == OP_REMU);
        end
    end
`endif

    // Next iteration state and final value of the current step
    always_comb begin
        w_acc_nxt = w_mul_acc;
        w_x_nxt   = r_x << 1;
        w_y_nxt   = r_y >> 1;
        w_fin     = w_mul_acc;
`ifdef ALU_DIV_EN
        if (r_div) begin
            w_acc_nxt = w_rem_nxt;
            w_x_nxt   = r_x;
            w_y_nxt   = w_quo_nxt;
            w_fin     = r_rem ? w_rem_nxt : w_quo_nxt;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_iter) begin
                            r_state <= S_RUN;
                            r_cnt   <= CNT_INIT;
                            r_acc   <= '0;
                            r_x     <= w_div_go ? b : a;
                            r_y     <= w_div_go ? a : b;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            r_ovf    <= w_ovf;
                            r_div0   <= w_div0;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    r_acc <= w_acc_nxt;
                    r_x   <= w_x_nxt;
                    r_y   <= w_y_nxt;
                    // Last step: publish directly from the step logic
                    if (r_cnt == CNT_ONE) begin
                        r_state  <= S_DONE;
                        r_result <= w_fin;
                        r_zero   <= (w_fin == '0);
                        r_ovf    <= 1'b0;
                        r_div0   <= 1'b0;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign zero   = r_zero;
    assign ovf    = r_ovf;
    assign div0   = r_div0;

endmodule
